// File: rtl/alu_mod_sequencer.sv
// Multi-cycle unsigned remainder (a mod b) by repeated subtraction on a shared ALU.
// Requests the ALU via alu_req/alu_gnt and stalls in place while the grant is withheld.
`timescale 1ns/1ps

module alu_mod_sequencer #(
    parameter int unsigned MAX_ITER = 1024,
    parameter int unsigned CNT_W    = 16
) (
    input  logic        clk,
    input  logic        reset,
    input  logic        start,
    input  logic [31:0] op_a,
    input  logic [31:0] op_b,
    input  logic        alu_gnt,
    input  logic [31:0] alu_result,
    output logic        alu_req,
    output logic [31:0] alu_src1,
    output logic [31:0] alu_src2,
    output logic [2:0]  alu_ctr,
    output logic        busy,
    output logic        done,
    output logic [1:0]  err,
    output logic [31:0] result
);

    localparam logic [1:0] ST_IDLE  = 2'd0;
    localparam logic [1:0] ST_CHECK = 2'd1;
    localparam logic [1:0] ST_SUB   = 2'd2;
    localparam logic [1:0] ST_DONE  = 2'd3;

    localparam logic [2:0] OP_NONE = 3'b000;
    localparam logic [2:0] OP_SLT  = 3'b100;
    localparam logic [2:0] OP_SUB  = 3'b110;

    localparam logic [1:0] ERR_OK    = 2'b00;
    localparam logic [1:0] ERR_DIV0  = 2'b01;
    localparam logic [1:0] ERR_NEG   = 2'b10;
    localparam logic [1:0] ERR_LIMIT = 2'b11;

    localparam logic [CNT_W-1:0] ITER_LIMIT = CNT_W'(MAX_ITER);

    logic [1:0]       r_state;
    logic [31:0]      r_rem;
    logic [31:0]      r_div;
    logic [CNT_W-1:0] r_iter;
    logic [31:0]      r_result;
    logic [1:0]       r_err;

    logic [1:0]       w_state_d;
    logic [31:0]      w_rem_d;
    logic [31:0]      w_div_d;
    logic [CNT_W-1:0] w_iter_d;
    logic [31:0]      w_result_d;
    logic [1:0]       w_err_d;
    logic             w_alu_active;

    always_comb begin
        w_state_d  = r_state;
        w_rem_d    = r_rem;
        w_div_d    = r_div;
        w_iter_d   = r_iter;
        w_result_d = r_result;
        w_err_d    = r_err;

        case (r_state)
            ST_IDLE: begin
                if (start) begin
                    w_rem_d  = op_a;
                    w_div_d  = op_b;
                    w_iter_d = '0;
                    // Divide-by-zero wins over the sign check.
                    if (op_b == 32'd0) begin
                        w_err_d    = ERR_DIV0;
                        w_result_d = 32'd0;
                        w_state_d  = ST_DONE;
                    end else if (op_a[31] || op_b[31]) begin
                        w_err_d    = ERR_NEG;
                        w_result_d = 32'd0;
                        w_state_d  = ST_DONE;
                    end else begin
                        w_err_d   = ERR_OK;
                        w_state_d = ST_CHECK;
                    end
                end
            end

            ST_CHECK: begin
                if (alu_gnt) begin
                    if (alu_result[0]) begin
                        w_result_d = r_rem;
                        w_state_d  = ST_DONE;
                    end else if (r_iter == ITER_LIMIT) begin
                        w_result_d = r_rem;
                        w_err_d    = ERR_LIMIT;
                        w_state_d  = ST_DONE;
                    end else begin
                        w_state_d = ST_SUB;
                    end
                end
            end

            ST_SUB: begin
                if (alu_gnt) begin
                    w_rem_d   = alu_result;
                    w_iter_d  = r_iter + 1'b1;
                    w_state_d = ST_CHECK;
                end
            end

            ST_DONE: begin
                w_state_d = ST_IDLE;
            end

            default: begin
                w_state_d = ST_IDLE;
            end
        endcase
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            r_state  <= ST_IDLE;
            r_rem    <= 32'd0;
            r_div    <= 32'd0;
            r_iter   <= '0;
            r_result <= 32'd0;
            r_err    <= ERR_OK;
        end else begin
            r_state  <= w_state_d;
            r_rem    <= w_rem_d;
            r_div    <= w_div_d;
            r_iter   <= w_iter_d;
            r_result <= w_result_d;
            r_err    <= w_err_d;
        end
    end

    // Operands are zeroed outside CHECK/SUB so nothing leaks onto the shared ALU mux.
    assign w_alu_active = (r_state == ST_CHECK) || (r_state == ST_SUB);

    always_comb begin
        alu_req  = w_alu_active;
        alu_src1 = w_alu_active ? r_rem : 32'd0;
        alu_src2 = w_alu_active ? r_div : 32'd0;
        case (r_state)
            ST_CHECK: alu_ctr = OP_SLT;
            ST_SUB:   alu_ctr = OP_SUB;
            default:  alu_ctr = OP_NONE;
        endcase
        busy   = (r_state != ST_IDLE);
        done   = (r_state == ST_DONE);
        err    = r_err;
        result = r_result;
    end

`ifndef SYNTHESIS
    a_done_pulse : assert property (@(posedge clk) disable iff (reset) done |=> !done);
    a_req_busy   : assert property (@(posedge clk) disable iff (reset) alu_req |-> busy);
    a_done_noreq : assert property (@(posedge clk) disable iff (reset) done |-> !alu_req);
`endif

endmodule

// File: doc/alu_mod_sequencer.md
Name: alu_mod_sequencer

Overview:
Multi-cycle controller that computes unsigned remainder (a mod b) by repeated subtraction on the shared 32-bit ALU. It drives the ALU's less-than (100) and sub (110) opcodes, because the ALU's 111 (MOD) slot returns 0. The block requests the ALU from the datapath via a req/gnt handshake and stalls while the grant is withheld. It sits beside the ALU, and its outputs are muxed onto the ALU inputs when the grant is high.

Parameters:
MAX_ITER, 1024, maximum subtract iterations before abort (must be >= 1)
CNT_W, 16, width of internal iteration counter (2^CNT_W > MAX_ITER)

Ports:
clk  input  1  clock; all state changes on rising edge
reset  input  1  asynchronous, active-high; clears all state
start  input  1  begin operation; sampled only in IDLE
op_a  input  32  dividend; sampled with start
op_b  input  32  divisor; sampled with start
alu_gnt  input  1  datapath grants ALU to this block this cycle
alu_result  input  32  ALU output for the current alu_src1/alu_src2/alu_ctr
alu_req  output  1  ALU request; high in CHECK and SUB
alu_src1  output  32  ALU operand 1 (remainder register)
alu_src2  output  32  ALU operand 2 (divisor register)
alu_ctr  output  3  ALU opcode: 100 in CHECK, 110 in SUB, 000 otherwise
busy  output  1  high in every state except IDLE
done  output  1  one-cycle pulse in DONE
err  output  2  00 ok, 01 divide-by-zero, 10 negative operand (bit 31 set), 11 iteration limit
result  output  32  remainder; valid when done is high; held until next start

Behaviour:
- Reset (async, any state): state=IDLE; rem, div, iter, result, err all 0; done=0; busy=0; alu_req=0; alu_ctr=000; alu_src1 and alu_src2 are 0.
- Operands must be non-negative (bit 31 = 0), so the ALU's less-than gives the same answer whether it is signed or unsigned.
- IDLE: on start=1, load rem<=op_a, div<=op_b, iter<=0.
  - If op_b==0: err<=01, go to DONE.
  - Else if op_a[31] or op_b[31] is set: err<=10, go to DONE.
  - Else: err<=00, go to CHECK.
  - divide-by-zero takes priority over negative operand.
- CHECK: alu_req=1, alu_ctr=100, alu_src1=rem, alu_src2=div.
  - If alu_gnt=0: hold state; ALU outputs unchanged.
  - If alu_gnt=1 and alu_result[0]=1 (rem<div): result<=rem, go to DONE.
  - Else if iter==MAX_ITER: result<=rem, err<=11, go to DONE.
  - Else: go to SUB.
- SUB: alu_req=1, alu_ctr=110, alu_src1=rem, alu_src2=div.
  - If alu_gnt=0: hold state.
  - If alu_gnt=1: rem<=alu_result, iter<=iter+1, go to CHECK.
- DONE: done=1 for exactly one cycle, busy=1, alu_req=0, then go to IDLE. result and err hold until the next accepted start.
- On error exits from IDLE (err 01/10), result<=0.
- start while busy: ignored; no queuing.
- Latency with continuous grant, start sampled at edge 0, quotient q: done is high in cycle 2+2q. Error exits from IDLE: done in cycle 1. Each grant-low cycle adds one cycle.
- Remainder never goes negative, because SUB is entered only when rem>=div.
- Grant loss mid-operation is legal in any CHECK/SUB cycle; the next granted cycle repeats the same ALU request.
- Reset mid-operation aborts immediately with no done pulse.

Test Plan:
- op_a=17, op_b=5, start 1 cycle, alu_gnt=1 -> alu_ctr sequence 100,110,100,110,100,110,100; done in cycle 8; result=2; err=00.
- op_a=3, op_b=7 -> single CHECK; done in cycle 2; result=3; err=00; alu_req high for 1 cycle only.
- op_b=0 (op_a=9) -> done in cycle 1, err=01, result=0, alu_req never asserted. op_a=0x80000000, op_b=3 -> err=10.
- MAX_ITER=4, op_a=100, op_b=1 -> done in cycle 10, err=11, result=96.
- op_a=17, op_b=5 with alu_gnt low for 3 cycles during the first SUB -> state/operands held; done in cycle 11; result=2; second start while busy ignored.
- Assert reset in cycle 4 of 17 mod 5 -> all outputs 0 asynchronously, no done pulse; a following start of 10 mod 4 gives result=2 in cycle 6.
